// File: rtl/bus_pma_gate_pkg.sv
// ============================================================================
// Module : p_hardisc (package)
// Brief  : Shared types for the PMA-gated bus bridge: region table entry,
//          default region, bridge FSM encoding and AHB HTRANS codes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package p_hardisc;

    // Region match: ((addr ^ base) & mask) == 0 above the PMA alignment.
    typedef struct packed {
        logic [31:0] base;
        logic [31:0] mask;
        logic        read_only;
        logic        executable;
        logic        idempotent;
    } pma_cfg_t;

    // Zero mask matches every address: a single fully permissive region.
    localparam pma_cfg_t PMA_DEFAULT = '{
        base:       32'h0000_0000,
        mask:       32'h0000_0000,
        read_only:  1'b0,
        executable: 1'b1,
        idempotent: 1'b1
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } gate_state_t;

    localparam logic [1:0] c_htrans_idle   = 2'b00;
    localparam logic [1:0] c_htrans_nonseq = 2'b10;

endpackage

`default_nettype wire

// File: rtl/bus_pma_gate_pma.sv
// ============================================================================
// Module : pma
// Brief  : Combinational physical-memory-attribute lookup; lowest-index
//          matching region wins, unmapped addresses are violations.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pma
    import p_hardisc::*;
#(
    parameter int unsigned                  FETCH       = 0,
    parameter int unsigned                  PMA_ALIGN   = 10,
    parameter int unsigned                  PMA_REGIONS = 1,
    parameter pma_cfg_t [PMA_REGIONS-1:0]   PMA_CFG     = '{default: PMA_DEFAULT}
)(
    input  logic [31:0] s_addr_i,
    input  logic        s_write_i,
    output logic        s_violation_o,
    output logic        s_idempotent_o
);

    localparam logic [31:0] c_align_mask = ~((32'h1 << PMA_ALIGN) - 32'h1);

    logic     w_hit;
    pma_cfg_t w_sel;

    always_comb begin
        w_hit = 1'b0;
        w_sel = '0;
        // Descending scan so the lowest-index match is the one left standing.
        for (int i = PMA_REGIONS - 1; i >= 0; i--) begin
            if (((s_addr_i ^ PMA_CFG[i].base) & PMA_CFG[i].mask & c_align_mask) == 32'h0) begin
                w_hit = 1'b1;
                w_sel = PMA_CFG[i];
            end
        end
    end

    always_comb begin
        if (FETCH != 0) begin
            s_violation_o = !w_hit || !w_sel.executable;
        end else begin
            s_violation_o = !w_hit || (s_write_i && w_sel.read_only);
        end
        s_idempotent_o = w_hit && w_sel.idempotent;
    end

endmodule

`default_nettype wire

// File: rtl/bus_pma_gate.sv
// ============================================================================
// Module : bus_pma_gate
// Brief  : Single-outstanding request-to-AHB-Lite bridge that rejects PMA
//          violations and misaligned accesses without touching the bus.
//          Optional bus timeout enabled by macro PMA_GATE_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_pma_gate
    import p_hardisc::*;
#(
    parameter int unsigned                  FETCH       = 0,
    parameter int unsigned                  PMA_ALIGN   = 10,
    parameter int unsigned                  PMA_REGIONS = 1,
    parameter pma_cfg_t [PMA_REGIONS-1:0]   PMA_CFG     = '{default: PMA_DEFAULT},
    parameter int unsigned                  TIMEOUT     = 255
)(
    input  logic        s_clk_i,
    input  logic        s_reset_i,

    input  logic        s_req_valid_i,
    output logic        s_req_ready_o,
    input  logic [31:0] s_req_addr_i,
    input  logic        s_req_write_i,
    input  logic [1:0]  s_req_size_i,
    input  logic [31:0] s_req_wdata_i,

    output logic        s_rsp_valid_o,
    output logic        s_rsp_error_o,
    output logic [31:0] s_rsp_rdata_o,
    output logic        s_rsp_idempotent_o,

    output logic [31:0] m_haddr_o,
    output logic [1:0]  m_htrans_o,
    output logic        m_hwrite_o,
    output logic [2:0]  m_hsize_o,
    output logic [31:0] m_hwdata_o,
    input  logic [31:0] m_hrdata_i,
    input  logic        m_hready_i,
    input  logic        m_hresp_i
`ifdef PMA_GATE_TIMEOUT_EN
    ,
    output logic        s_timeout_o
`endif
);

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_range
        $error("bus_pma_gate: TIMEOUT out of range 1..65535");
    end

    gate_state_t r_state;
    gate_state_t w_next;

    logic [31:0] r_addr;
    logic        r_write;
    logic [1:0]  r_size;
    logic [31:0] r_wdata;
    logic        r_idem;
    logic        r_error;
    logic [31:0] r_rdata;

    logic w_violation;
    logic w_pma_idem;
    logic w_misaligned;
    logic w_accept;
    logic w_reject;
    logic w_timeout;

    pma #(
        .FETCH       (FETCH),
        .PMA_ALIGN   (PMA_ALIGN),
        .PMA_REGIONS (PMA_REGIONS),
        .PMA_CFG     (PMA_CFG)
    ) u_pma (
        .s_addr_i       (s_req_addr_i),
        .s_write_i      (s_req_write_i),
        .s_violation_o  (w_violation),
        .s_idempotent_o (w_pma_idem)
    );

    always_comb begin
        case (s_req_size_i)
            2'd0:    w_misaligned = 1'b0;
            2'd1:    w_misaligned = s_req_addr_i[0];
            2'd2:    w_misaligned = (s_req_addr_i[1:0] != 2'b00);
            default: w_misaligned = 1'b1;
        endcase
    end

    assign w_accept = s_req_valid_i && (r_state == ST_IDLE);
    assign w_reject = w_violation || w_misaligned;

`ifdef PMA_GATE_TIMEOUT_EN
    localparam logic [15:0] c_tmo_last = 16'(TIMEOUT - 1);

    logic [15:0] r_tmo_cnt;
    logic        r_timeout;

    assign w_timeout = ((r_state == ST_ADDR) || (r_state == ST_DATA)) &&
                       !m_hready_i && (r_tmo_cnt == c_tmo_last);

    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            r_tmo_cnt <= 16'h0;
            r_timeout <= 1'b0;
        end else begin
            if (w_accept && !w_reject) begin
                r_tmo_cnt <= 16'h0;
            end else if (((r_state == ST_ADDR) || (r_state == ST_DATA)) && !m_hready_i) begin
                r_tmo_cnt <= r_tmo_cnt + 16'h1;
            end
            if (w_timeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign s_timeout_o = r_timeout;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = w_reject ? ST_RESP : ST_ADDR;
            ST_ADDR: if (w_timeout) w_next = ST_RESP;
                     else if (m_hready_i) w_next = ST_DATA;
            ST_DATA: if (w_timeout || m_hready_i) w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            r_addr  <= 32'h0;
            r_write <= 1'b0;
            r_size  <= 2'd0;
            r_wdata <= 32'h0;
            r_idem  <= 1'b0;
            r_error <= 1'b0;
            r_rdata <= 32'h0;
        end else if (w_accept) begin
            r_idem  <= w_pma_idem;
            r_error <= w_reject;
            r_rdata <= 32'h0;
            // Rejected requests leave the bus-side registers untouched.
            if (!w_reject) begin
                r_addr  <= s_req_addr_i;
                r_write <= s_req_write_i;
                r_size  <= s_req_size_i;
                r_wdata <= s_req_wdata_i;
            end
        end else if (w_timeout) begin
            r_error <= 1'b1;
            r_rdata <= 32'h0;
        end else if ((r_state == ST_DATA) && m_hready_i) begin
            r_error <= m_hresp_i;
            r_rdata <= (!r_write && !m_hresp_i) ? m_hrdata_i : 32'h0;
        end
    end

    always_comb begin
        s_req_ready_o      = (r_state == ST_IDLE);
        s_rsp_valid_o      = (r_state == ST_RESP);
        s_rsp_error_o      = (r_state == ST_RESP) && r_error;
        s_rsp_rdata_o      = ((r_state == ST_RESP) && !r_error) ? r_rdata : 32'h0;
        s_rsp_idempotent_o = (r_state == ST_RESP) && r_idem;
        m_htrans_o         = (r_state == ST_ADDR) ? c_htrans_nonseq : c_htrans_idle;
        m_haddr_o          = r_addr;
        m_hwrite_o         = r_write;
        m_hsize_o          = {1'b0, r_size};
        m_hwdata_o         = r_wdata;
    end

endmodule

`default_nettype wire
